// File: rtl/first_pkg.sv
// Shared constants and helpers for the first_mod status decoder.
package first_pkg;

    localparam int FIRST_W_DEFAULT = 2;

    // Produces the all-ones pattern for a code of the given width (1..16)
    function automatic logic [31:0] all_ones(input int width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/first_wrap_det.sv
// Wrap detector: remembers the previous code and pulses when the code
// moves from all-ones straight to zero.
module first_wrap_det
    import first_pkg::*;
#(
    parameter int WIDTH = FIRST_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sample,
    output logic             wrap_pulse
);

    localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(all_ones(WIDTH));

    logic [WIDTH-1:0] in_q;

    // Previous-sample history and the registered wrap pulse; clearing in_q on
    // reset means the first edge after release can never report a wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_q       <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            in_q       <= sample;
            wrap_pulse <= (sample == '0) && (in_q == ALL_ONES);
        end
    end

endmodule

// File: rtl/first_mod.sv
// Registered status decoder: flags a monitored code as all-ones, non-zero,
// and pulses once each time it wraps from all-ones back to zero.
module first_mod
    import first_pkg::*;
#(
    parameter int WIDTH = FIRST_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] first_in,
    output logic             first_out1,
    output logic             first_out2,
    output logic             first_out3
);

    localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(all_ones(WIDTH));

    // Level flags are registered so every output comes straight from a flop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_out1 <= 1'b0;
            first_out2 <= 1'b0;
        end else begin
            first_out1 <= (first_in == ALL_ONES);
            first_out2 <= (first_in != '0);
        end
    end

    first_wrap_det #(
        .WIDTH(WIDTH)
    ) u_wrap_det (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample    (first_in),
        .wrap_pulse(first_out3)
    );

endmodule

// File: tb/tb_first_mod.sv
// Directed bench for first_mod: a default 2-bit instance and a 1-bit instance
// driven in lockstep, with hand-computed expected flag sequences.
module tb_first_mod;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] in2 = '0;
    logic       in1 = 1'b0;
    logic       a_out1, a_out2, a_out3;
    logic       b_out1, b_out2, b_out3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    first_mod #(.WIDTH(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .first_in  (in2),
        .first_out1(a_out1),
        .first_out2(a_out2),
        .first_out3(a_out3)
    );

    first_mod #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .first_in  (in1),
        .first_out1(b_out1),
        .first_out2(b_out2),
        .first_out3(b_out3)
    );

    // Drives one sample, lets it be taken on the next rising edge, and
    // returns shortly after so the outputs seen belong to that sample
    task automatic applyStimulus(input logic [1:0] v2, input logic v1, input logic rst);
        in2   = v2;
        in1   = v1;
        rst_n = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
        end
    endtask

    initial begin
        int sweep_in[9];
        int sweep_o1[9];
        int sweep_o2[9];
        int sweep_o3[9];
        int nw_in[4];
        int nw_o2[4];
        int hold_in[4];
        int hold_o3[4];
        int w1_in[4];
        int w1_o[4];
        int w1_o3[4];

        sweep_in = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
        sweep_o1 = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
        sweep_o2 = '{0, 1, 1, 1, 0, 1, 1, 1, 0};
        sweep_o3 = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
        nw_in    = '{2, 0, 1, 0};
        nw_o2    = '{1, 0, 1, 0};
        hold_in  = '{3, 0, 0, 0};
        hold_o3  = '{0, 1, 0, 0};
        w1_in    = '{1, 0, 1, 0};
        w1_o     = '{1, 0, 1, 0};
        w1_o3    = '{0, 1, 0, 1};

        $display("[TB] reset with input held at all-ones");
        for (int i = 0; i < 3; i++) applyStimulus(2'd3, 1'b1, 1'b0);
        checkOutput("rst_out1", a_out1, 1'b0);
        checkOutput("rst_out2", a_out2, 1'b0);
        checkOutput("rst_out3", a_out3, 1'b0);
        checkOutput("rst_w1_out1", b_out1, 1'b0);
        applyStimulus(2'd3, 1'b1, 1'b1);
        checkOutput("rel_out1", a_out1, 1'b1);
        checkOutput("rel_out2", a_out2, 1'b1);
        checkOutput("rel_out3", a_out3, 1'b0);

        $display("[TB] count sweep");
        applyStimulus(2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(2'(sweep_in[i]), 1'b0, 1'b1);
            checkOutput($sformatf("sweep_out1[%0d]", i), a_out1, 1'(sweep_o1[i]));
            checkOutput($sformatf("sweep_out2[%0d]", i), a_out2, 1'(sweep_o2[i]));
            checkOutput($sformatf("sweep_out3[%0d]", i), a_out3, 1'(sweep_o3[i]));
        end

        $display("[TB] non-wrap transitions into zero");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'(nw_in[i]), 1'b0, 1'b1);
            checkOutput($sformatf("nowrap_out2[%0d]", i), a_out2, 1'(nw_o2[i]));
            checkOutput($sformatf("nowrap_out3[%0d]", i), a_out3, 1'b0);
        end

        $display("[TB] zero held after a wrap");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'(hold_in[i]), 1'b0, 1'b1);
            checkOutput($sformatf("hold_out3[%0d]", i), a_out3, 1'(hold_o3[i]));
        end

        $display("[TB] reset straddling a wrap");
        applyStimulus(2'd3, 1'b0, 1'b1);
        checkOutput("midrst_pre_out1", a_out1, 1'b1);
        applyStimulus(2'd0, 1'b0, 1'b0);
        checkOutput("midrst_rst_out3", a_out3, 1'b0);
        checkOutput("midrst_rst_out1", a_out1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(2'd0, 1'b0, 1'b1);
            checkOutput($sformatf("midrst_out3[%0d]", i), a_out3, 1'b0);
        end

        $display("[TB] one-bit instance");
        applyStimulus(2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'd0, 1'(w1_in[i]), 1'b1);
            checkOutput($sformatf("w1_out1[%0d]", i), b_out1, 1'(w1_o[i]));
            checkOutput($sformatf("w1_out2[%0d]", i), b_out2, 1'(w1_o[i]));
            checkOutput($sformatf("w1_out3[%0d]", i), b_out3, 1'(w1_o3[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
